// File: rtl/rgb_colour_encoder.sv
// rgb_colour_encoder: maps a 24-bit RGB code back to its 3-bit {R,G,B} colour
// index by sequentially searching a writable 8-entry palette table.
module rgb_colour_encoder #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned DATA_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              req,
    input  logic [DATA_W-1:0] rgb_in,
    output logic              busy,
    output logic              valid,
    output logic              hit,
    output logic [IDX_W-1:0]  colour
);

    localparam int unsigned CH_W = DATA_W / IDX_W;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              busy_d, valid_d, hit_d;
    logic [IDX_W-1:0]  colour_d;
    logic [DATA_W-1:0] tbl [ENTRIES];

    // Default palette: each index bit fully saturates its own colour channel.
    function automatic logic [DATA_W-1:0] palette(input int unsigned i);
        logic [IDX_W-1:0]  b;
        logic [DATA_W-1:0] val;
        b   = IDX_W'(i);
        val = '0;
        for (int unsigned c = 0; c < IDX_W; c++) begin
            val[c*CH_W +: CH_W] = {CH_W{b[c]}};
        end
        return val;
    endfunction

    // Palette storage: default colours on reset, otherwise single-port writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tbl[i] <= palette(i);
            end
        end else if (wr_en) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            key_q   <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            hit     <= 1'b0;
            colour  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            busy    <= busy_d;
            valid   <= valid_d;
            hit     <= hit_d;
            colour  <= colour_d;
        end
    end

    // Next-state and next-output logic; one table entry compared per cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        key_d    = key_q;
        busy_d   = 1'b0;
        valid_d  = 1'b0;
        hit_d    = hit;
        colour_d = colour;
        case (state_q)
            IDLE: begin
                if (req) begin
                    key_d   = rgb_in;
                    idx_d   = '0;
                    state_d = SEARCH;
                    busy_d  = 1'b1;
                end
            end
            SEARCH: begin
                if (tbl[idx_q] == key_q) begin
                    colour_d = idx_q;
                    hit_d    = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else if (idx_q == IDX_W'(ENTRIES - 1)) begin
                    colour_d = '0;
                    hit_d    = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rgb_colour_encoder.sv
// Directed self-checking bench for rgb_colour_encoder.
module tb_rgb_colour_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic        req;
    logic [23:0] rgb_in;
    logic        busy;
    logic        valid;
    logic        hit;
    logic [2:0]  colour;

    int n_cmp = 0;
    int n_err = 0;

    rgb_colour_encoder #(
        .ENTRIES(8),
        .IDX_W  (3),
        .DATA_W (24)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .req    (req),
        .rgb_in (rgb_in),
        .busy   (busy),
        .valid  (valid),
        .hit    (hit),
        .colour (colour)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until valid (bounded); lat counts edges, busy_ok tracks busy before valid.
    task automatic wait_result(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (valid) return;
            if (!busy) busy_ok = 1'b0;
        end
        lat = 99;
    endtask

    task automatic wr(input logic [2:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Full lookup: accept, wait, then check latency and result fields.
    task automatic lookup(input string tag, input logic [23:0] key, input int exp_lat,
                          input logic exp_hit, input logic [2:0] exp_col);
        int lat;
        bit bok;
        req    = 1'b1;
        rgb_in = key;
        tick();
        req    = 1'b0;
        rgb_in = '0;
        wait_result(lat, bok);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_during"}, bok, 1'b1);
        chk({tag, "_hit"}, hit, exp_hit);
        chk({tag, "_colour"}, colour, exp_col);
        chk({tag, "_busy_at_valid"}, busy, 1'b0);
    endtask

    initial begin
        int lat;
        bit bok;
        bit pre_ok;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; req = 1'b0; rgb_in = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_hit", hit, 1'b0);
        chk("rst_colour", colour, 3'd0);

        // Red at index 4: 5 cycles
        lookup("red", 24'hFF0000, 5, 1'b1, 3'd4);
        tick();
        chk("red_valid_one_cycle", valid, 1'b0);
        chk("red_hit_held", hit, 1'b1);
        chk("red_colour_held", colour, 3'd4);

        // Black at index 0, then a miss
        lookup("black", 24'h000000, 1, 1'b1, 3'd0);
        lookup("miss", 24'h123456, 8, 1'b0, 3'd0);

        // Reprogram entry 2, then duplicate at 6: lowest index wins
        wr(3'd2, 24'h123456);
        lookup("wr2", 24'h123456, 3, 1'b1, 3'd2);
        wr(3'd6, 24'h123456);
        lookup("dup", 24'h123456, 3, 1'b1, 3'd2);

        // req while busy is ignored (a restart on 0000FF would hit at index 1)
        req    = 1'b1;
        rgb_in = 24'hFFFFFF;
        tick();
        rgb_in = 24'h0000FF;
        pre_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid || !busy) pre_ok = 1'b0;
        end
        req    = 1'b0;
        rgb_in = '0;
        chk("ign_no_early_valid", pre_ok, 1'b1);
        wait_result(lat, bok);
        chk("ign_lat", 3 + lat, 8);
        chk("ign_hit", hit, 1'b1);
        chk("ign_colour", colour, 3'd7);
        // Back-to-back: req in the valid cycle
        req    = 1'b1;
        rgb_in = 24'h000000;
        tick();
        req    = 1'b0;
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_valid_low", valid, 1'b0);
        wait_result(lat, bok);
        chk("b2b_lat", lat, 1);
        chk("b2b_hit", hit, 1'b1);
        chk("b2b_colour", colour, 3'd0);

        // Write to the entry under comparison does not affect that compare
        req    = 1'b1;
        rgb_in = 24'hABCDEF;
        tick();
        req    = 1'b0;
        tick();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'hABCDEF;
        tick();
        wr_en = 1'b0;
        wait_result(lat, bok);
        chk("midwr_lat", 2 + lat, 8);
        chk("midwr_hit", hit, 1'b0);
        chk("midwr_colour", colour, 3'd0);
        lookup("midwr_took", 24'hABCDEF, 2, 1'b1, 3'd1);
        wr(3'd1, 24'h0000FF);

        // Write to a not-yet-searched entry does affect the result
        req    = 1'b1;
        rgb_in = 24'hABCDEF;
        tick();
        req    = 1'b0;
        tick();
        tick();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 24'hABCDEF;
        tick();
        wr_en = 1'b0;
        wait_result(lat, bok);
        chk("ahead_lat", 3 + lat, 6);
        chk("ahead_hit", hit, 1'b1);
        chk("ahead_colour", colour, 3'd5);

        // Reset mid-search: no valid, outputs cleared, palette restored
        wr(3'd0, 24'hFFFFFF);
        req    = 1'b1;
        rgb_in = 24'h5A5A5A;
        tick();
        req    = 1'b0;
        pre_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (valid) pre_ok = 1'b0;
        end
        rst   = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 24'h000000;
        req   = 1'b1;
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        req   = 1'b0;
        if (valid) pre_ok = 1'b0;
        chk("rst2_busy", busy, 1'b0);
        chk("rst2_hit", hit, 1'b0);
        chk("rst2_colour", colour, 3'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid || busy) pre_ok = 1'b0;
        end
        chk("rst2_no_valid", pre_ok, 1'b1);
        lookup("rst2_white", 24'hFFFFFF, 8, 1'b1, 3'd7);
        lookup("rst2_e2_default", 24'h123456, 8, 1'b0, 3'd0);
        lookup("rst2_green", 24'h00FF00, 3, 1'b1, 3'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
